// File: rtl/rcs_pc_controller.sv
// rcs_pc_controller: sequences one column of reconfigurable cells through a
// config-load phase and an execute phase, owning the shared global PC.
// Optional feature macro: CGRA_PERF_CNT_EN enables the execute-phase cycle and
// stall counters; without it both counter outputs are tied to 0.
// The PC width defaults to RCS_NUM_CREG_LOG2 (5 when not otherwise defined).

`ifndef RCS_NUM_CREG_LOG2
`define RCS_NUM_CREG_LOG2 5
`endif

module rcs_pc_controller #(
    parameter int N_RC  = 4,
    parameter int PC_W  = `RCS_NUM_CREG_LOG2,
    parameter int CNT_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_req_i,
    input  logic [PC_W:0]        load_len_i,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic                 start_i,
    input  logic [PC_W-1:0]      start_pc_i,
    input  logic                 abort_i,
    input  logic [N_RC-1:0]      rc_stall_i,
    input  logic [N_RC-1:0]      rc_br_req_i,
    input  logic [N_RC*PC_W-1:0] rc_br_add_i,
    input  logic [N_RC-1:0]      rc_exec_end_i,
    output logic [PC_W-1:0]      global_pc_o,
    output logic                 pc_en_o,
    output logic                 conf_we_o,
    output logic                 conf_re_o,
    output logic                 busy_o,
    output logic                 load_done_o,
    output logic                 exec_done_o,
    output logic                 br_conflict_o,
    output logic [CNT_W-1:0]     exec_cycles_o,
    output logic [CNT_W-1:0]     stall_cycles_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // A load length of 0 stands for the full config depth.
    localparam logic [PC_W:0] FULL_LEN = {1'b1, {PC_W{1'b0}}};
    localparam logic [PC_W:0] LAST_LEN = {{PC_W{1'b0}}, 1'b1};

    state_t          r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [PC_W:0]   r_cnt, w_cnt_nxt;

    logic            w_br_found;
    logic            w_br_diff;
    logic [PC_W-1:0] w_br_target;
    logic            w_start_acc;

    assign global_pc_o = r_pc;
    assign busy_o      = (r_state != S_IDLE);
    assign w_start_acc = (r_state == S_IDLE) && !load_req_i && start_i;

    // Branch resolution: lowest-index requester wins; flag any requester whose target differs.
    always_comb begin
        w_br_found  = 1'b0;
        w_br_diff   = 1'b0;
        w_br_target = '0;
        for (int i = 0; i < N_RC; i++) begin
            if (rc_br_req_i[i]) begin
                if (!w_br_found) begin
                    w_br_found  = 1'b1;
                    w_br_target = rc_br_add_i[i*PC_W +: PC_W];
                end else if (rc_br_add_i[i*PC_W +: PC_W] != w_br_target) begin
                    w_br_diff = 1'b1;
                end
            end
        end
    end

    // Next-state, next-PC/count and all phase outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_cnt_nxt     = r_cnt;
        instr_ready_o = 1'b0;
        pc_en_o       = 1'b0;
        conf_we_o     = 1'b0;
        conf_re_o     = 1'b0;
        load_done_o   = 1'b0;
        exec_done_o   = 1'b0;
        br_conflict_o = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (load_req_i) begin
                    w_state_nxt = S_LOAD;
                    w_pc_nxt    = '0;
                    w_cnt_nxt   = (load_len_i == '0) ? FULL_LEN : load_len_i;
                end else if (start_i) begin
                    w_state_nxt = S_EXEC;
                    w_pc_nxt    = start_pc_i;
                end
            end

            S_LOAD: begin
                if (abort_i) begin
                    w_state_nxt = S_IDLE;
                    w_pc_nxt    = '0;
                end else begin
                    instr_ready_o = 1'b1;
                    if (instr_valid_i) begin
                        conf_we_o = 1'b1;
                        pc_en_o   = 1'b1;
                        w_pc_nxt  = r_pc + 1'b1;
                        w_cnt_nxt = r_cnt - 1'b1;
                        if (r_cnt == LAST_LEN) begin
                            load_done_o = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end

            S_EXEC: begin
                if (abort_i) begin
                    w_state_nxt = S_IDLE;
                    w_pc_nxt    = '0;
                end else begin
                    conf_re_o = 1'b1;
                    pc_en_o   = ~|rc_stall_i;
                    if (pc_en_o) begin
                        if (|rc_exec_end_i) begin
                            w_state_nxt = S_DONE;
                        end else if (w_br_found) begin
                            w_pc_nxt      = w_br_target;
                            br_conflict_o = w_br_diff;
                        end else begin
                            w_pc_nxt = r_pc + 1'b1;
                        end
                    end
                end
            end

            S_DONE: begin
                exec_done_o = 1'b1;
                w_pc_nxt    = '0;
                w_state_nxt = S_IDLE;
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, PC and remaining-word count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifdef CGRA_PERF_CNT_EN
    logic [CNT_W-1:0] r_exec_cycles;
    logic [CNT_W-1:0] r_stall_cycles;

    // Saturating execute/stall counters, cleared when a start is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_exec_cycles  <= '0;
            r_stall_cycles <= '0;
        end else if (w_start_acc) begin
            r_exec_cycles  <= '0;
            r_stall_cycles <= '0;
        end else if (r_state == S_EXEC) begin
            if (r_exec_cycles != '1) begin
                r_exec_cycles <= r_exec_cycles + 1'b1;
            end
            if (!pc_en_o && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    assign exec_cycles_o  = r_exec_cycles;
    assign stall_cycles_o = r_stall_cycles;
`else
    logic w_unused_start_acc;
    assign w_unused_start_acc = w_start_acc;
    assign exec_cycles_o      = '0;
    assign stall_cycles_o     = '0;
`endif

endmodule
